// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard controller for the five-stage MIPS pipeline. It shadows the
//   destination register and result readiness (tnew) of the instructions in
//   E, M and W. From that it drives the operand-forwarding mux selects in D,
//   E and M. It also raises the single stall that holds PC and F/D and
//   bubbles E.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   d_rs, d_rt          D-stage source registers
//   d_rs_tuse/d_rt_tuse cycles after D until operand is consumed (3 = never)
//   d_dst, d_tnew       D-stage destination (0 = none) and result latency
//   d_md_use            D instruction touches the mult/div unit
//   md_start, md_is_div E instruction starts mult (0) / div (1) this cycle
//   stall               hold PC and F/D, bubble into E
//   fwd_d_rs/fwd_d_rt   D compare mux: 0 regfile, 1 E, 2 M, 3 W
//   fwd_e_rs/fwd_e_rt   ALU input mux: 0 D/E latched, 2 M, 3 W
//   fwd_m_rt            store-data mux: 0 E/M latched, 1 W
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_rs_tuse,
    input  logic [1:0] d_rt_tuse,
    input  logic [4:0] d_dst,
    input  logic [1:0] d_tnew,
    input  logic       d_md_use,
    input  logic       md_start,
    input  logic       md_is_div,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       fwd_m_rt
);

    localparam logic [3:0] MULT_CYC = 4'd5;
    localparam logic [3:0] DIV_CYC  = 4'd10;

    logic [4:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d, e_dst_q, e_dst_d;
    logic [1:0] e_tnew_q, e_tnew_d;
    logic [4:0] m_rt_q, m_rt_d, m_dst_q, m_dst_d;
    logic [1:0] m_tnew_q, m_tnew_d;
    logic [4:0] w_dst_q, w_dst_d;
    logic [3:0] md_cnt_q, md_cnt_d;

    // A source conflicts if any in-flight producer of it (E or M) will not
    // have its result ready by the time the operand is consumed.
    function automatic logic src_hazard(input logic [4:0] s, input logic [1:0] tuse);
        return (s != 5'd0) &&
               (((s == e_dst_q) && (e_tnew_q > tuse)) ||
                ((s == m_dst_q) && (m_tnew_q > tuse)));
    endfunction

    // Nearest producer wins. If it is not ready yet, fall back to the
    // regfile/latched value; the stall or a later forward covers it.
    function automatic logic [1:0] sel_d(input logic [4:0] s);
        if (s == 5'd0)     return 2'd0;
        if (s == e_dst_q)  return (e_tnew_q == 2'd0) ? 2'd1 : 2'd0;
        if (s == m_dst_q)  return (m_tnew_q == 2'd0) ? 2'd2 : 2'd0;
        if (s == w_dst_q)  return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic [4:0] s);
        if (s == 5'd0)     return 2'd0;
        if (s == m_dst_q)  return (m_tnew_q == 2'd0) ? 2'd2 : 2'd0;
        if (s == w_dst_q)  return 2'd3;
        return 2'd0;
    endfunction

    always_comb begin
        stall = src_hazard(d_rs, d_rs_tuse) ||
                src_hazard(d_rt, d_rt_tuse) ||
                (d_md_use && ((md_cnt_q != 4'd0) || md_start));

        fwd_d_rs = sel_d(d_rs);
        fwd_d_rt = sel_d(d_rt);
        fwd_e_rs = sel_e(e_rs_q);
        fwd_e_rt = sel_e(e_rt_q);
        fwd_m_rt = (m_rt_q != 5'd0) && (m_rt_q == w_dst_q);
    end

    always_comb begin
        // Stalled D instruction stays in F/D; E gets an all-zero bubble.
        e_rs_d   = stall ? 5'd0 : d_rs;
        e_rt_d   = stall ? 5'd0 : d_rt;
        e_dst_d  = stall ? 5'd0 : d_dst;
        e_tnew_d = stall ? 2'd0 : d_tnew;

        m_rt_d   = e_rt_q;
        m_dst_d  = e_dst_q;
        m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;

        w_dst_d  = m_dst_q;

        // md_start comes from E and is accepted even while D is stalled.
        if (md_start)
            md_cnt_d = md_is_div ? DIV_CYC : MULT_CYC;
        else if (md_cnt_q != 4'd0)
            md_cnt_d = md_cnt_q - 4'd1;
        else
            md_cnt_d = 4'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_rs_q   <= 5'd0;
            e_rt_q   <= 5'd0;
            e_dst_q  <= 5'd0;
            e_tnew_q <= 2'd0;
            m_rt_q   <= 5'd0;
            m_dst_q  <= 5'd0;
            m_tnew_q <= 2'd0;
            w_dst_q  <= 5'd0;
            md_cnt_q <= 4'd0;
        end else begin
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            e_dst_q  <= e_dst_d;
            e_tnew_q <= e_tnew_d;
            m_rt_q   <= m_rt_d;
            m_dst_q  <= m_dst_d;
            m_tnew_q <= m_tnew_d;
            w_dst_q  <= w_dst_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed vector table followed by random
// stimulus compared against a stage-list reference model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic       d_md_use, md_start, md_is_div;
    logic       stall, fwd_m_rt;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_dst(d_dst), .d_tnew(d_tnew), .d_md_use(d_md_use),
        .md_start(md_start), .md_is_div(md_is_div),
        .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt, dst;
        logic [1:0] tus, tut, tn;
        logic       mdu, mds, mdd, chk;
        logic [9:0] exp_o; // {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt}
    } vec_t;

    vec_t tbl[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: list of instructions in E (0), M (1), W (2) with the
    // tnew each had on entering E; readiness is derived from stage depth.
    typedef struct {
        logic [4:0] rs, rt, dst;
        int         tnew;
    } stage_t;
    stage_t st[3];
    int     cyc = 0;
    int     busy_end = 0;

    function automatic int rem(int k);
        int t;
        t = st[k].tnew - k;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic logic src_hz(logic [4:0] s, logic [1:0] tuse);
        if (s == 5'd0) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (st[k].dst == s && rem(k) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] sel(logic [4:0] s, int first);
        if (s == 5'd0) return 2'd0;
        for (int k = first; k < 3; k++)
            if (st[k].dst == s) return (k == 2 || rem(k) == 0) ? 2'(k + 1) : 2'd0;
        return 2'd0;
    endfunction

    function automatic logic [9:0] model_out();
        logic s;
        s = src_hz(d_rs, d_rs_tuse) || src_hz(d_rt, d_rt_tuse) ||
            (d_md_use && (cyc < busy_end || md_start));
        return {s, sel(d_rs, 0), sel(d_rt, 0), sel(st[0].rs, 1), sel(st[0].rt, 1),
                (st[1].rt != 5'd0 && st[1].rt == st[2].dst)};
    endfunction

    task automatic model_step(input logic s);
        if (reset) begin
            for (int k = 0; k < 3; k++) st[k] = '{5'd0, 5'd0, 5'd0, 0};
            busy_end = 0;
        end else begin
            st[2] = st[1];
            st[1] = st[0];
            if (s) st[0] = '{5'd0, 5'd0, 5'd0, 0};
            else   st[0] = '{d_rs, d_rt, d_dst, int'(d_tnew)};
            if (md_start) busy_end = cyc + (md_is_div ? 10 : 5) + 1;
        end
        cyc++;
    endtask

    task automatic add(int r, int rs, int rt, int tus, int tut, int dst, int tn,
                       int mdu, int mds, int mdd, int chk, logic [9:0] e);
        vec_t v;
        v.rst = 1'(r); v.rs = 5'(rs); v.rt = 5'(rt); v.tus = 2'(tus); v.tut = 2'(tut);
        v.dst = 5'(dst); v.tn = 2'(tn); v.mdu = 1'(mdu); v.mds = 1'(mds); v.mdd = 1'(mdd);
        v.chk = 1'(chk); v.exp_o = e;
        tbl.push_back(v);
    endtask

    task automatic nops(int n, logic [9:0] e);
        for (int i = 0; i < n; i++) add(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, e);
    endtask

    function automatic logic [9:0] dut_out();
        return {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt};
    endfunction

    // Drive one cycle; compare either against the given expectation (table)
    // or against the model (random), then advance the model with the edge.
    task automatic apply(input vec_t v, input bit use_model, input int idx);
        logic [9:0] m, e;
        reset = v.rst; d_rs = v.rs; d_rt = v.rt; d_rs_tuse = v.tus; d_rt_tuse = v.tut;
        d_dst = v.dst; d_tnew = v.tn; d_md_use = v.mdu; md_start = v.mds; md_is_div = v.mdd;
        @(negedge clk);
        m = model_out();
        e = use_model ? m : v.exp_o;
        if (v.chk) begin
            vectors++;
            if (dut_out() !== e) begin
                miscompares++;
                $display("FAIL %s[%0d] got %b expected %b (stall,fd_rs,fd_rt,fe_rs,fe_rt,fm_rt)",
                         use_model ? "rand" : "tbl", idx, dut_out(), e);
            end
        end
        model_step(m[9]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        for (int k = 0; k < 3; k++) st[k] = '{5'd0, 5'd0, 5'd0, 0};
        #1;

        // Reset for two cycles with random D inputs, then all-quiet outputs.
        for (int i = 0; i < 2; i++)
            add(1, int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
                int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                int'($urandom_range(31, 0)), int'($urandom_range(3, 0)),
                int'($urandom_range(1, 0)), int'($urandom_range(1, 0)),
                int'($urandom_range(1, 0)), 0, 10'b0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10'b0);

        // ALU producer $3 then dependent ALU reader: no stall, E forward from M.
        add(0, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 10'b0_00_00_00_00_0);
        add(0, 3, 5, 1, 1, 4, 1, 0, 0, 0, 1, 10'b0_00_00_00_00_0);
        add(0, 6, 7, 1, 1, 8, 1, 0, 0, 0, 1, 10'b0_00_00_10_00_0);
        nops(3, 10'b0);

        // lw $5 then beq $5 (tuse 0): two stall cycles then W forward.
        add(0, 1, 0, 1, 3, 5, 2, 0, 0, 0, 1, 10'b0_00_00_00_00_0);
        add(0, 5, 6, 0, 0, 0, 0, 0, 0, 0, 1, 10'b1_00_00_00_00_0);
        add(0, 5, 6, 0, 0, 0, 0, 0, 0, 0, 1, 10'b1_00_00_00_00_0);
        add(0, 5, 6, 0, 0, 0, 0, 0, 0, 0, 1, 10'b0_11_00_00_00_0);
        nops(3, 10'b0);

        // Two ready writers of $7: E wins; then not-ready E writer.
        add(0, 0, 0, 3, 3, 7, 0, 0, 0, 0, 1, 10'b0);
        add(0, 0, 0, 3, 3, 7, 0, 0, 0, 0, 1, 10'b0);
        add(0, 7, 7, 0, 1, 9, 1, 0, 0, 0, 1, 10'b0_01_01_00_00_0);
        add(0, 0, 0, 3, 3, 7, 1, 0, 0, 0, 1, 10'b0_00_00_10_10_0);
        add(0, 7, 7, 0, 1, 0, 0, 0, 0, 0, 1, 10'b1_00_00_00_00_1);
        add(0, 7, 7, 0, 1, 0, 0, 0, 0, 0, 1, 10'b0_10_10_00_00_0);
        add(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 10'b0_00_00_11_11_0);
        nops(2, 10'b0);

        // div then mflo: 11 stall cycles, released when the counter is 0.
        add(0, 1, 2, 1, 1, 0, 1, 1, 0, 0, 1, 10'b0);
        add(0, 0, 0, 3, 3, 4, 1, 1, 1, 1, 1, 10'b1_00_00_00_00_0);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 3, 3, 4, 1, 1, 0, 0, 1, 10'b1_00_00_00_00_0);
        add(0, 0, 0, 3, 3, 4, 1, 1, 0, 0, 1, 10'b0);
        nops(3, 10'b0);

        // mult then mfhi: 6 stall cycles.
        add(0, 1, 2, 1, 1, 0, 1, 1, 0, 0, 1, 10'b0);
        add(0, 0, 0, 3, 3, 4, 1, 1, 1, 0, 1, 10'b1_00_00_00_00_0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 3, 3, 4, 1, 1, 0, 0, 1, 10'b1_00_00_00_00_0);
        add(0, 0, 0, 3, 3, 4, 1, 1, 0, 0, 1, 10'b0);
        nops(3, 10'b0);

        // div busy, reset (with a competing md_start) at busy cycle 4.
        add(0, 1, 2, 1, 1, 0, 1, 1, 0, 0, 1, 10'b0);
        add(0, 0, 0, 3, 3, 4, 1, 1, 1, 1, 1, 10'b1_00_00_00_00_0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 3, 3, 4, 1, 1, 0, 0, 1, 10'b1_00_00_00_00_0);
        add(1, 0, 0, 3, 3, 4, 1, 1, 1, 1, 1, 10'b1_00_00_00_00_0);
        add(0, 0, 0, 3, 3, 4, 1, 1, 0, 0, 1, 10'b0);
        nops(3, 10'b0);

        // $0 producers and readers never stall or forward.
        add(0, 0, 0, 3, 3, 0, 2, 0, 0, 0, 1, 10'b0);
        add(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 10'b0);
        add(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 10'b0);

        // ALU producer then tuse-0 branch: one stall, then M forward.
        add(0, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 10'b0);
        add(0, 3, 0, 0, 3, 0, 0, 0, 0, 0, 1, 10'b1_00_00_00_00_0);
        add(0, 3, 0, 0, 3, 0, 0, 0, 0, 0, 1, 10'b0_10_00_00_00_0);

        foreach (tbl[i]) apply(tbl[i], 1'b0, i);

        // Random phase against the reference model.
        v = '{1'b1, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0};
        apply(v, 1'b1, -2);
        apply(v, 1'b1, -1);
        for (int i = 0; i < 3000; i++) begin
            v.rst = ($urandom_range(63, 0) == 0);
            v.rs  = 5'($urandom_range(7, 0));
            v.rt  = 5'($urandom_range(7, 0));
            v.dst = 5'($urandom_range(7, 0));
            v.tus = 2'($urandom_range(3, 0));
            v.tut = 2'($urandom_range(3, 0));
            v.tn  = 2'($urandom_range(3, 0));
            v.mdu = ($urandom_range(3, 0) == 0);
            v.mds = ($urandom_range(7, 0) == 0);
            v.mdd = 1'($urandom_range(1, 0));
            v.chk = 1'b1;
            apply(v, 1'b1, i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
